// File: rtl/cap_pkg.sv
// cap_pkg: shared state encoding and default widths for the ADC capture controller.
package cap_pkg;
    localparam int CAP_ADDR_W = 14;
    localparam int CAP_DATA_W = 64;
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } cap_state_e;
endpackage

// File: rtl/cap_rd_pipe.sv
// cap_rd_pipe: delays each read grant by RD_LAT cycles to strobe returned RAM data.
module cap_rd_pipe
    import cap_pkg::*;
#(
    parameter int RD_LAT = 2,
    parameter int DATA_W = CAP_DATA_W
) (
    input  logic              i_125clk,
    input  logic              i_nreset,
    input  logic              i_gnt,
    input  logic [DATA_W-1:0] i_ram_q,
    output logic              o_rd_valid,
    output logic [DATA_W-1:0] o_rd_data
);
    logic [RD_LAT-1:0] vld;
    always_ff @(posedge i_125clk or negedge i_nreset)
        if (!i_nreset)
            vld <= '0;
        else
            vld <= RD_LAT'({vld, i_gnt});
    assign o_rd_valid = vld[RD_LAT-1];
    assign o_rd_data  = o_rd_valid ? i_ram_q : '0;
endmodule

// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: pre/post-trigger ADC capture into a circular RAM with host readback.
module adc_capture_ctrl
    import cap_pkg::*;
#(
    parameter int ADDR_W = CAP_ADDR_W,
    parameter int DATA_W = CAP_DATA_W,
    parameter int RD_LAT = 2
) (
    input  logic                i_125clk,
    input  logic                i_nreset,
    input  logic [DATA_W-1:0]   i_adc_data,
    input  logic                i_adc_valid,
    input  logic                i_arm,
    input  logic                i_trig,
    input  logic [ADDR_W-1:0]   i_post_len,
    input  logic                i_rd_req,
    input  logic [ADDR_W-1:0]   i_rd_addr,
    output logic                o_rd_gnt,
    output logic                o_rd_valid,
    output logic [DATA_W-1:0]   o_rd_data,
    output logic [DATA_W-1:0]   o_ram_data,
    output logic [ADDR_W-1:0]   o_ram_address,
    output logic [DATA_W/8-1:0] o_ram_byteen,
    output logic                o_ram_wbit,
    input  logic [DATA_W-1:0]   i_ram_q,
    output logic [1:0]          o_state,
    output logic [ADDR_W-1:0]   o_trig_addr,
    output logic                o_done
);
    localparam logic [1:0] IDLE    = S_IDLE;
    localparam logic [1:0] ARMED   = S_ARMED;
    localparam logic [1:0] CAPTURE = S_CAPTURE;
    localparam logic [1:0] DONE    = S_DONE;

    logic [1:0]        state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] remain;
    logic              host_side;
    logic              fire;

    assign host_side     = state == IDLE || state == DONE;
    assign o_ram_wbit    = i_nreset && !host_side && i_adc_valid;
    assign o_rd_gnt      = i_nreset && host_side && i_rd_req;
    assign fire          = state == ARMED && i_adc_valid && i_trig;
    assign o_ram_data    = o_ram_wbit ? i_adc_data : '0;
    assign o_ram_byteen  = o_ram_wbit ? '1 : '0;
    assign o_ram_address = o_ram_wbit ? wr_ptr : o_rd_gnt ? i_rd_addr : '0;
    assign o_state       = state;
    assign o_done        = state == DONE;

    // remain counts post-trigger samples still owed after the current one; a length of 0 wraps to the full RAM.
    always_ff @(posedge i_125clk or negedge i_nreset)
        if (!i_nreset) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            remain      <= '0;
            o_trig_addr <= '0;
        end else begin
            if (o_ram_wbit)
                wr_ptr <= wr_ptr + ADDR_W'(1);
            if (host_side && i_arm) begin
                state       <= ARMED;
                wr_ptr      <= '0;
                o_trig_addr <= '0;
            end else if (fire) begin
                state       <= i_post_len == ADDR_W'(1) ? DONE : CAPTURE;
                remain      <= i_post_len - ADDR_W'(1);
                o_trig_addr <= wr_ptr;
            end else if (state == CAPTURE && i_adc_valid) begin
                state  <= remain == ADDR_W'(1) ? DONE : CAPTURE;
                remain <= remain - ADDR_W'(1);
            end
        end

    cap_rd_pipe #(
        .RD_LAT (RD_LAT),
        .DATA_W (DATA_W)
    ) u_rd_pipe (
        .i_125clk   (i_125clk),
        .i_nreset   (i_nreset),
        .i_gnt      (o_rd_gnt),
        .i_ram_q    (i_ram_q),
        .o_rd_valid (o_rd_valid),
        .o_rd_data  (o_rd_data)
    );
endmodule

// File: tb/tb_adc_capture_ctrl.sv
// tb_adc_capture_ctrl: directed scoreboard bench for adc_capture_ctrl with a 2-cycle RAM model.
module tb_adc_capture_ctrl;
    localparam logic [63:0] PA = 64'hA000_0000_0000_0000;
    localparam logic [63:0] PB = 64'hB000_0000_0000_0000;
    localparam logic [63:0] PC = 64'hC000_0000_0000_0000;
    localparam logic [63:0] PD = 64'hD000_0000_0000_0000;
    localparam logic [63:0] PF = 64'hF000_0000_0000_0000;

    typedef struct {
        logic [13:0] addr;
        logic [63:0] data;
    } wr_t;
    typedef struct {
        int          due;
        logic [63:0] data;
    } rd_t;

    logic        clk = 1'b0;
    logic        i_nreset;
    logic [63:0] i_adc_data;
    logic        i_adc_valid;
    logic        i_arm;
    logic        i_trig;
    logic [13:0] i_post_len;
    logic        i_rd_req;
    logic [13:0] i_rd_addr;
    logic        o_rd_gnt;
    logic        o_rd_valid;
    logic [63:0] o_rd_data;
    logic [63:0] o_ram_data;
    logic [13:0] o_ram_address;
    logic [7:0]  o_ram_byteen;
    logic        o_ram_wbit;
    logic [63:0] i_ram_q;
    logic [1:0]  o_state;
    logic [13:0] o_trig_addr;
    logic        o_done;

    wr_t         wq[$];
    rd_t         rq[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc_n = 0;
    logic [63:0] mem[0:16383];
    logic [63:0] q1, q2;

    adc_capture_ctrl dut (
        .i_125clk      (clk),
        .i_nreset      (i_nreset),
        .i_adc_data    (i_adc_data),
        .i_adc_valid   (i_adc_valid),
        .i_arm         (i_arm),
        .i_trig        (i_trig),
        .i_post_len    (i_post_len),
        .i_rd_req      (i_rd_req),
        .i_rd_addr     (i_rd_addr),
        .o_rd_gnt      (o_rd_gnt),
        .o_rd_valid    (o_rd_valid),
        .o_rd_data     (o_rd_data),
        .o_ram_data    (o_ram_data),
        .o_ram_address (o_ram_address),
        .o_ram_byteen  (o_ram_byteen),
        .o_ram_wbit    (o_ram_wbit),
        .i_ram_q       (i_ram_q),
        .o_state       (o_state),
        .o_trig_addr   (o_trig_addr),
        .o_done        (o_done)
    );

    always #4 clk = ~clk;

    // RAM with two registered read stages
    always @(posedge clk) begin
        cyc_n <= cyc_n + 1;
        if (o_ram_wbit) mem[o_ram_address] <= o_ram_data;
        q1 <= mem[o_ram_address];
        q2 <= q1;
    end
    assign i_ram_q = q2;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic exp_wr(input int a, input logic [63:0] d);
        wr_t e;
        e.addr = 14'(a);
        e.data = d;
        wq.push_back(e);
    endtask

    task automatic exp_rd(input int due, input logic [63:0] d);
        rd_t e;
        e.due  = due;
        e.data = d;
        rq.push_back(e);
    endtask

    // Drive one cycle's inputs, then score any write or read return the DUT shows.
    task automatic drive(input logic v, input logic [63:0] d, input logic t, input logic a);
        wr_t w;
        rd_t r;
        i_adc_valid = v;
        i_adc_data  = d;
        i_trig      = t;
        i_arm       = a;
        #1;
        if (o_ram_wbit) begin
            chk("write_pending", 64'(wq.size() != 0), 64'd1);
            if (wq.size() != 0) begin
                w = wq.pop_front();
                chk("wr_addr", 64'(o_ram_address), 64'(w.addr));
                chk("wr_data", o_ram_data, w.data);
                chk("wr_byteen", 64'(o_ram_byteen), 64'hff);
            end
        end
        if (o_rd_valid) begin
            chk("read_pending", 64'(rq.size() != 0), 64'd1);
            if (rq.size() != 0) begin
                r = rq.pop_front();
                chk("rd_cycle", 64'(cyc_n), 64'(r.due));
                chk("rd_data", o_rd_data, r.data);
            end
        end
    endtask

    task automatic cyc(input logic v, input logic [63:0] d, input logic t, input logic a);
        drive(v, d, t, a);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        i_nreset = 1'b0; i_adc_data = '0; i_adc_valid = 1'b0; i_arm = 1'b0; i_trig = 1'b0;
        i_post_len = 14'd5; i_rd_req = 1'b0; i_rd_addr = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_state", 64'(o_state), 64'd0);
        chk("rst_done", 64'(o_done), 64'd0);
        chk("rst_wbit", 64'(o_ram_wbit), 64'd0);
        chk("rst_byteen", 64'(o_ram_byteen), 64'd0);
        chk("rst_trig_addr", 64'(o_trig_addr), 64'd0);
        chk("rst_rd_valid", 64'(o_rd_valid), 64'd0);
        @(negedge clk);
        i_nreset = 1'b1;
        cyc(1'b1, 64'd1, 1'b1, 1'b0);
        chk("idle_trig_ignored", 64'(o_state), 64'd0);

        // 20 samples, trigger on sample 10, post length 5
        cyc(1'b0, '0, 1'b0, 1'b1);
        chk("armed", 64'(o_state), 64'd1);
        for (int i = 0; i < 20; i++) begin
            if (i <= 14) exp_wr(i, PA + 64'(i));
            cyc(1'b1, PA + 64'(i), i == 10 || i == 17, 1'b0);
            if (i == 9) chk("pre_trig_state", 64'(o_state), 64'd1);
            if (i == 10) begin
                chk("trig_state", 64'(o_state), 64'd2);
                chk("trig_addr", 64'(o_trig_addr), 64'd10);
                i_post_len = 14'd100;
            end
            if (i == 13) chk("capture_before_last", 64'(o_state), 64'd2);
            if (i == 14) begin
                chk("done_state", 64'(o_state), 64'd3);
                chk("done_flag", 64'(o_done), 64'd1);
            end
        end
        chk("trig_addr_held", 64'(o_trig_addr), 64'd10);
        chk("wq_empty_capture", 64'(wq.size()), 64'd0);

        // back-to-back reads in DONE
        for (int i = 0; i < 4; i++) begin
            i_rd_req  = 1'b1;
            i_rd_addr = 14'(7 + i);
            exp_rd(cyc_n + 2, PA + 64'(7 + i));
            drive(1'b0, '0, 1'b0, 1'b0);
            chk("rd_gnt", 64'(o_rd_gnt), 64'd1);
            chk("rd_ram_addr", 64'(o_ram_address), 64'(7 + i));
            chk("rd_no_write", 64'(o_ram_wbit), 64'd0);
            @(negedge clk);
        end
        i_rd_req = 1'b0;
        repeat (3) cyc(1'b0, '0, 1'b0, 1'b0);
        chk("rq_empty_reads", 64'(rq.size()), 64'd0);

        // read in flight across re-arm; no grant once ARMED
        i_rd_req  = 1'b1;
        i_rd_addr = 14'd3;
        exp_rd(cyc_n + 2, PA + 64'd3);
        drive(1'b1, 64'hDEAD, 1'b0, 1'b1);
        chk("arm_cycle_gnt", 64'(o_rd_gnt), 64'd1);
        chk("arm_cycle_no_write", 64'(o_ram_wbit), 64'd0);
        @(negedge clk);
        chk("rearmed", 64'(o_state), 64'd1);
        exp_wr(0, PB);
        drive(1'b1, PB, 1'b0, 1'b0);
        chk("armed_no_gnt", 64'(o_rd_gnt), 64'd0);
        @(negedge clk);
        i_rd_req = 1'b0;
        for (int k = 1; k < 16390; k++) begin
            exp_wr(k % 16384, PB + 64'(k));
            cyc(1'b1, PB + 64'(k), 1'b0, 1'b0);
        end
        chk("wrap_still_armed", 64'(o_state), 64'd1);
        chk("wq_empty_wrap", 64'(wq.size()), 64'd0);
        chk("rq_empty_arm", 64'(rq.size()), 64'd0);

        // trigger qualified by valid, stalls, arm ignored in CAPTURE
        i_post_len = 14'd3;
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("no_trig_invalid", 64'(o_state), 64'd1);
        exp_wr(6, PC);
        cyc(1'b1, PC, 1'b1, 1'b0);
        chk("trig_on_valid", 64'(o_state), 64'd2);
        chk("trig_addr_wrap", 64'(o_trig_addr), 64'd6);
        cyc(1'b0, '0, 1'b1, 1'b1);
        chk("stall_state", 64'(o_state), 64'd2);
        exp_wr(7, PC + 64'd1);
        cyc(1'b1, PC + 64'd1, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        exp_wr(8, PC + 64'd2);
        cyc(1'b1, PC + 64'd2, 1'b0, 1'b0);
        chk("done_len3", 64'(o_state), 64'd3);

        // post length 0 captures the full RAM
        i_post_len = 14'd0;
        cyc(1'b0, '0, 1'b0, 1'b1);
        exp_wr(0, PD);
        cyc(1'b1, PD, 1'b1, 1'b0);
        chk("full_capture", 64'(o_state), 64'd2);
        for (int k = 1; k < 16384; k++) begin
            exp_wr(k, PD + 64'(k));
            cyc(1'b1, PD + 64'(k), 1'b0, 1'b0);
            if (k == 16382) chk("full_not_done", 64'(o_state), 64'd2);
        end
        chk("full_done", 64'(o_state), 64'd3);
        cyc(1'b1, 64'hE, 1'b0, 1'b0);
        chk("wq_empty_full", 64'(wq.size()), 64'd0);

        // asynchronous reset mid-CAPTURE
        i_post_len = 14'd10;
        cyc(1'b0, '0, 1'b0, 1'b1);
        exp_wr(0, PF);
        cyc(1'b1, PF, 1'b1, 1'b0);
        exp_wr(1, PF + 64'd1);
        cyc(1'b1, PF + 64'd1, 1'b0, 1'b0);
        chk("mid_capture", 64'(o_state), 64'd2);
        i_adc_valid = 1'b1;
        i_nreset    = 1'b0;
        #1;
        chk("async_rst_wbit", 64'(o_ram_wbit), 64'd0);
        chk("async_rst_state", 64'(o_state), 64'd0);
        chk("async_rst_trig_addr", 64'(o_trig_addr), 64'd0);
        @(negedge clk);
        cyc(1'b1, PF + 64'd2, 1'b0, 1'b0);
        i_nreset = 1'b1;
        cyc(1'b1, PF + 64'd3, 1'b1, 1'b0);
        chk("post_rst_idle", 64'(o_state), 64'd0);
        chk("wq_empty_rst", 64'(wq.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
